// File: rtl/fir_channel_scheduler.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fir_channel_scheduler
//
// Shares a single AXI-Stream FIR instance between NUM_CH microphone channels.
// Each channel keeps one pending sample. A round-robin arbiter picks the next
// pending channel and issues its sample to the FIR. It then waits for the
// result and returns it on that channel's output slice. Only one sample is
// ever in flight at the FIR.
//
// Parameters
//   WIDTH    sample width for input, FIR and output data
//   NUM_CH   number of channels sharing the FIR
//   TIMEOUT  WAIT cycles allowed for a FIR result before it is abandoned
//
// Ports (audio_clk domain)
//   clk_in          clock
//   rst_in          synchronous, active-high reset
//   ch_valid_in     per-channel 1-cycle sample strobe
//   ch_data_in      channel i sample at [i*WIDTH +: WIDTH], signed
//   fir_tvalid_out  FIR s_axis tvalid
//   fir_tdata_out   FIR s_axis tdata
//   fir_tready_in   FIR s_axis tready
//   fir_tvalid_in   FIR m_axis tvalid
//   fir_tdata_in    FIR m_axis tdata
//   ch_valid_out    per-channel 1-cycle result strobe (one-hot or zero)
//   ch_data_out     per-channel result, held until that channel's next result
//   overrun_out     sticky per-channel lost-sample flag
//   timeout_out     sticky missing-FIR-result flag
//   busy_out        high whenever the scheduler is not IDLE
// ----------------------------------------------------------------------------
module fir_channel_scheduler #(
  parameter int WIDTH   = 16,
  parameter int NUM_CH  = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_CH-1:0]       ch_valid_in,
  input  logic [NUM_CH*WIDTH-1:0] ch_data_in,
  output logic                    fir_tvalid_out,
  output logic [WIDTH-1:0]        fir_tdata_out,
  input  logic                    fir_tready_in,
  input  logic                    fir_tvalid_in,
  input  logic [WIDTH-1:0]        fir_tdata_in,
  output logic [NUM_CH-1:0]       ch_valid_out,
  output logic [NUM_CH*WIDTH-1:0] ch_data_out,
  output logic [NUM_CH-1:0]       overrun_out,
  output logic                    timeout_out,
  output logic                    busy_out
);

  localparam int CH_W  = (NUM_CH > 1)  ? $clog2(NUM_CH)  : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Last channel index: reset value of last_grant so that channel 0 wins first.
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                  state;
  logic [NUM_CH-1:0]       pend;
  logic signed [WIDTH-1:0] pend_data [NUM_CH];
  logic [CH_W-1:0]         last_grant;
  logic [CH_W-1:0]         cur_ch;
  logic [CNT_W-1:0]        wait_cnt;

  logic                    grant_vld;
  logic [CH_W-1:0]         grant_ch;
  logic                    grant_fire;

  // Round-robin pick: the first requester after 'last', wrapping modulo
  // NUM_CH. The loop walks from the farthest candidate to the nearest, so
  // the nearest pending channel overwrites any farther one and wins.
  // Result is {found, index}.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [CH_W-1:0]   last);
    logic [CH_W:0] pick;
    int            idx;
    pick = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[CH_W'(idx)]) pick = {1'b1, CH_W'(idx)};
    end
    return pick;
  endfunction

  assign {grant_vld, grant_ch} = rr_pick(pend, last_grant);
  assign grant_fire            = (state == IDLE) && grant_vld;
  assign busy_out              = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      pend           <= '0;
      for (int i = 0; i < NUM_CH; i++) pend_data[i] <= '0;
      fir_tvalid_out <= 1'b0;
      fir_tdata_out  <= '0;
      ch_valid_out   <= '0;
      ch_data_out    <= '0;
      overrun_out    <= '0;
      timeout_out    <= 1'b0;
      wait_cnt       <= '0;
      last_grant     <= LAST_CH;
      cur_ch         <= '0;
    end else begin
      ch_valid_out <= '0;

      // Capture stage: per-channel pending slot. A channel granted in the
      // same cycle its new sample arrives issues the old value and keeps the
      // new one pending, so that case is not an overrun.
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid_in[i]) begin
          pend[i]      <= 1'b1;
          pend_data[i] <= ch_data_in[i*WIDTH +: WIDTH];
          if (pend[i] && !(grant_fire && (grant_ch == CH_W'(i))))
            overrun_out[i] <= 1'b1;
        end else if (grant_fire && (grant_ch == CH_W'(i))) begin
          pend[i] <= 1'b0;
        end
      end

      // Issue / return stage: one sample in flight at the FIR.
      case (state)
        IDLE: begin
          if (grant_vld) begin
            cur_ch         <= grant_ch;
            fir_tdata_out  <= pend_data[grant_ch];
            fir_tvalid_out <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (fir_tready_in) begin
            fir_tvalid_out <= 1'b0;
            wait_cnt       <= '0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (fir_tvalid_in) begin
            ch_data_out[cur_ch*WIDTH +: WIDTH] <= fir_tdata_in;
            ch_valid_out[cur_ch]               <= 1'b1;
            last_grant                         <= cur_ch;
            state                              <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            // The FIR lost this sample: drop it and move the round-robin on.
            timeout_out <= 1'b1;
            last_grant  <= cur_ch;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
`timescale 1ns/1ps
// Bench for fir_channel_scheduler: vector table, directed corner sequences
// and a randomized run scored against per-channel expected sample streams.
module tb_fir_channel_scheduler;

  localparam int W   = 16;
  localparam int NCH = 3;
  localparam int TO  = 64;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [NCH-1:0]   ch_valid_in;
  logic [NCH*W-1:0] ch_data_in;
  logic             fir_tvalid_out;
  logic [W-1:0]     fir_tdata_out;
  logic             fir_tready_in;
  logic             fir_tvalid_in;
  logic [W-1:0]     fir_tdata_in;
  logic [NCH-1:0]   ch_valid_out;
  logic [NCH*W-1:0] ch_data_out;
  logic [NCH-1:0]   overrun_out;
  logic             timeout_out;
  logic             busy_out;

  fir_channel_scheduler #(.WIDTH(W), .NUM_CH(NCH), .TIMEOUT(TO)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .ch_valid_in    (ch_valid_in),
    .ch_data_in     (ch_data_in),
    .fir_tvalid_out (fir_tvalid_out),
    .fir_tdata_out  (fir_tdata_out),
    .fir_tready_in  (fir_tready_in),
    .fir_tvalid_in  (fir_tvalid_in),
    .fir_tdata_in   (fir_tdata_in),
    .ch_valid_out   (ch_valid_out),
    .ch_data_out    (ch_data_out),
    .overrun_out    (overrun_out),
    .timeout_out    (timeout_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] d;
  } ev_t;

  typedef struct packed {
    logic [2:0]       mask;
    logic [2:0][15:0] d;
    int               lat;
    int               n;
    logic [2:0][1:0]  ech;
    logic [2:0][15:0] ed;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   fir_lat = 4;
  int   fir_n;
  bit   fir_drop = 1'b0;
  bit   fir_rand = 1'b0;
  logic [15:0] fir_d;
  logic [15:0] fir_log[$];
  ev_t  out_log[$];
  ev_t  in_log[$];
  logic [2:0] prev_vo = '0;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    rst_in      = 1'b1;
    ch_valid_in = '0;
    tick;
    tick;
    rst_in = 1'b0;
  endtask

  task automatic clear_logs;
    out_log.delete();
    fir_log.delete();
  endtask

  task automatic strobe(input logic [2:0] m, input logic [15:0] a, b, c);
    ch_valid_in = m;
    ch_data_in  = {c, b, a};
    tick;
    ch_valid_in = '0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int t;
    t = 0;
    while (out_log.size() < n && t < budget) begin
      @(negedge clk_in);
      t++;
    end
    chk("wait_out_reached", 64'(out_log.size() >= n), 64'd1);
  endtask

  task automatic wait_hs(input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk_in);
      t++;
    end while (!(fir_tvalid_out && fir_tready_in) && t < budget);
    chk("wait_handshake", 64'(fir_tvalid_out && fir_tready_in), 64'd1);
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_fir_tvalid"}, 64'(fir_tvalid_out), 64'd0);
    chk({p, "_fir_tdata"},  64'(fir_tdata_out),  64'd0);
    chk({p, "_ch_valid"},   64'(ch_valid_out),   64'd0);
    chk({p, "_ch_data"},    64'(ch_data_out),    64'd0);
    chk({p, "_overrun"},    64'(overrun_out),    64'd0);
    chk({p, "_timeout"},    64'(timeout_out),    64'd0);
    chk({p, "_busy"},       64'(busy_out),       64'd0);
  endtask

  function automatic vec_t mk(input logic [2:0] m, input logic [15:0] a, b, c,
                              input int lat, input int n,
                              input logic [1:0] c0, c1, c2,
                              input logic [15:0] e0, e1, e2);
    vec_t v;
    v.mask = m;
    v.d[0] = a;  v.d[1] = b;  v.d[2] = c;
    v.lat  = lat;
    v.n    = n;
    v.ech[0] = c0; v.ech[1] = c1; v.ech[2] = c2;
    v.ed[0]  = e0; v.ed[1]  = e1; v.ed[2]  = e2;
    return v;
  endfunction

  // FIR model: accepts a sample on handshake and echoes it after fir_n cycles.
  initial begin
    fir_tvalid_in = 1'b0;
    fir_tdata_in  = '0;
    forever begin
      @(negedge clk_in);
      if (fir_tvalid_out && fir_tready_in) begin
        fir_d = fir_tdata_out;
        fir_log.push_back(fir_d);
        fir_n = fir_rand ? int'($urandom_range(1, 4)) : fir_lat;
        repeat (fir_n) @(posedge clk_in);
        #1;
        if (!fir_drop) begin
          fir_tvalid_in = 1'b1;
          fir_tdata_in  = fir_d;
          @(posedge clk_in);
          #1;
          fir_tvalid_in = 1'b0;
        end
      end
    end
  end

  // Output monitor: logs every result pulse, checks one-hot and 1-cycle width.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk_in);
      if (ch_valid_out != '0) begin
        chk("onehot_valid_out", 64'($onehot0(ch_valid_out)), 64'd1);
        chk("pulse_width", 64'(prev_vo), 64'd0);
        for (int c = 0; c < NCH; c++) begin
          if (ch_valid_out[c]) begin
            e.ch = 2'(c);
            e.d  = ch_data_out[c*W +: W];
            out_log.push_back(e);
          end
        end
      end
      prev_vo = ch_valid_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] qi[$];
    logic [15:0] qo[$];
    logic [15:0] hold_d;
    int   last_t[NCH];
    int   lowrun;
    int   nmin;
    ev_t  e;
    logic [NCH-1:0]   vmask;
    logic [NCH*W-1:0] vdata;
    logic [15:0]      rd;

    tbl[0] = mk(3'b001, 16'h1234, 16'h0000, 16'h0000, 8, 1, 2'd0, 2'd0, 2'd0, 16'h1234, 16'h0000, 16'h0000);
    tbl[1] = mk(3'b111, 16'hAAAA, 16'hBBBB, 16'hCCCC, 8, 3, 2'd0, 2'd1, 2'd2, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    tbl[2] = mk(3'b110, 16'h0000, 16'h8000, 16'h7FFF, 1, 2, 2'd1, 2'd2, 2'd0, 16'h8000, 16'h7FFF, 16'h0000);
    tbl[3] = mk(3'b100, 16'h0000, 16'h0000, 16'hFFFF, 3, 1, 2'd2, 2'd0, 2'd0, 16'hFFFF, 16'h0000, 16'h0000);
    tbl[4] = mk(3'b101, 16'h0001, 16'h0000, 16'hFFFE, 5, 2, 2'd0, 2'd2, 2'd0, 16'h0001, 16'hFFFE, 16'h0000);
    tbl[5] = mk(3'b010, 16'h0000, 16'h5A5A, 16'h0000, 2, 1, 2'd1, 2'd0, 2'd0, 16'h5A5A, 16'h0000, 16'h0000);

    rst_in        = 1'b1;
    ch_valid_in   = '0;
    ch_data_in    = '0;
    fir_tready_in = 1'b1;
    tick;
    tick;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk_all_zero("reset");

    // Table-driven single-burst vectors.
    for (int v = 0; v < 6; v++) begin
      tick;
      do_reset;
      clear_logs;
      fir_lat       = tbl[v].lat;
      fir_tready_in = 1'b1;
      strobe(tbl[v].mask, tbl[v].d[0], tbl[v].d[1], tbl[v].d[2]);
      wait_out(tbl[v].n, 300);
      repeat (10) tick;
      chk($sformatf("v%0d_out_count", v), 64'(out_log.size()), 64'(tbl[v].n));
      chk($sformatf("v%0d_fir_count", v), 64'(fir_log.size()), 64'(tbl[v].n));
      for (int j = 0; j < tbl[v].n; j++) begin
        if (j < out_log.size()) begin
          chk($sformatf("v%0d_out%0d_ch", v, j),   64'(out_log[j].ch), 64'(tbl[v].ech[j]));
          chk($sformatf("v%0d_out%0d_data", v, j), 64'(out_log[j].d),  64'(tbl[v].ed[j]));
        end
        if (j < fir_log.size())
          chk($sformatf("v%0d_fir%0d_data", v, j), 64'(fir_log[j]), 64'(tbl[v].ed[j]));
        chk($sformatf("v%0d_hold%0d", v, j),
            64'(ch_data_out[tbl[v].ech[j]*W +: W]), 64'(tbl[v].ed[j]));
      end
      for (int c = 0; c < NCH; c++)
        if (!tbl[v].mask[c])
          chk($sformatf("v%0d_untouched_ch%0d", v, c), 64'(ch_data_out[c*W +: W]), 64'd0);
      chk($sformatf("v%0d_overrun", v), 64'(overrun_out), 64'd0);
      chk($sformatf("v%0d_timeout", v), 64'(timeout_out), 64'd0);
    end

    // Reset clears results left by the table vectors.
    do_reset;
    @(negedge clk_in);
    chk_all_zero("reset2");

    // Strobe-to-tvalid latency with tready high.
    tick;
    clear_logs;
    fir_lat = 3;
    strobe(3'b001, 16'h0F0F, 16'h0000, 16'h0000);
    @(negedge clk_in);
    chk("lat_tvalid_early", 64'(fir_tvalid_out), 64'd0);
    @(negedge clk_in);
    chk("lat_tvalid", 64'(fir_tvalid_out), 64'd1);
    chk("lat_tdata", 64'(fir_tdata_out), 64'h0F0F);
    wait_out(1, 50);

    // Backpressure: tvalid/tdata held for 20 cycles, then a single handshake.
    tick;
    do_reset;
    clear_logs;
    fir_tready_in = 1'b0;
    fir_lat       = 4;
    strobe(3'b001, 16'hBEEF, 16'h0000, 16'h0000);
    @(negedge clk_in);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      chk($sformatf("bp_tvalid_c%0d", k), 64'(fir_tvalid_out), 64'd1);
      chk($sformatf("bp_tdata_c%0d", k),  64'(fir_tdata_out),  64'hBEEF);
    end
    tick;
    fir_tready_in = 1'b1;
    wait_out(1, 50);
    repeat (10) tick;
    chk("bp_handshakes", 64'(fir_log.size()), 64'd1);
    chk("bp_out_count",  64'(out_log.size()), 64'd1);
    if (out_log.size() > 0) chk("bp_out_data", 64'(out_log[0].d), 64'hBEEF);

    // Overrun on channel 1 while the FIR is blocked on channel 0.
    do_reset;
    clear_logs;
    fir_tready_in = 1'b0;
    fir_lat       = 2;
    strobe(3'b001, 16'h1111, 16'h0000, 16'h0000);
    tick;
    tick;
    strobe(3'b010, 16'h0000, 16'h0001, 16'h0000);
    tick;
    strobe(3'b010, 16'h0000, 16'h0002, 16'h0000);
    @(negedge clk_in);
    chk("ovr_flag", 64'(overrun_out), 64'b010);
    tick;
    fir_tready_in = 1'b1;
    wait_out(2, 100);
    repeat (10) tick;
    chk("ovr_fir_count", 64'(fir_log.size()), 64'd2);
    if (fir_log.size() > 1) begin
      chk("ovr_fir0", 64'(fir_log[0]), 64'h1111);
      chk("ovr_fir1", 64'(fir_log[1]), 64'h0002);
    end
    chk("ovr_ch1_data", 64'(ch_data_out[1*W +: W]), 64'h0002);
    chk("ovr_sticky", 64'(overrun_out), 64'b010);
    chk("ovr_timeout", 64'(timeout_out), 64'd0);

    // New sample arrives on the very cycle its channel is granted.
    do_reset;
    clear_logs;
    fir_tready_in = 1'b0;
    fir_lat       = 2;
    strobe(3'b010, 16'h0000, 16'h2222, 16'h0000);
    tick;
    strobe(3'b001, 16'h3333, 16'h0000, 16'h0000);
    tick;
    fir_tready_in = 1'b1;
    begin
      int t;
      t = 0;
      do begin
        @(negedge clk_in);
        t++;
      end while (busy_out && t < 50);
      chk("same_cycle_idle_seen", 64'(busy_out), 64'd0);
    end
    ch_valid_in = 3'b001;
    ch_data_in  = {16'h0000, 16'h0000, 16'h4444};
    tick;
    ch_valid_in = '0;
    wait_out(3, 100);
    repeat (10) tick;
    chk("same_cycle_fir_count", 64'(fir_log.size()), 64'd3);
    if (fir_log.size() > 2) begin
      chk("same_cycle_fir0", 64'(fir_log[0]), 64'h2222);
      chk("same_cycle_fir1", 64'(fir_log[1]), 64'h3333);
      chk("same_cycle_fir2", 64'(fir_log[2]), 64'h4444);
    end
    chk("same_cycle_overrun", 64'(overrun_out), 64'd0);
    chk("same_cycle_ch0_data", 64'(ch_data_out[0 +: W]), 64'h4444);

    // Timeout: the FIR never answers.
    do_reset;
    clear_logs;
    fir_drop = 1'b1;
    fir_lat  = 2;
    strobe(3'b100, 16'h0000, 16'h0000, 16'h5555);
    wait_hs(10);
    repeat (TO) @(negedge clk_in);
    chk("to_before_flag", 64'(timeout_out), 64'd0);
    chk("to_before_busy", 64'(busy_out), 64'd1);
    @(negedge clk_in);
    chk("to_flag", 64'(timeout_out), 64'd1);
    chk("to_idle", 64'(busy_out), 64'd0);
    chk("to_no_pulse", 64'(out_log.size()), 64'd0);
    fir_drop = 1'b0;
    tick;
    strobe(3'b001, 16'h6666, 16'h0000, 16'h0000);
    wait_out(1, 100);
    if (out_log.size() > 0) begin
      chk("to_next_ch",   64'(out_log[0].ch), 64'd0);
      chk("to_next_data", 64'(out_log[0].d),  64'h6666);
    end
    chk("to_sticky", 64'(timeout_out), 64'd1);

    // Reset while waiting for a FIR result.
    tick;
    do_reset;
    clear_logs;
    fir_lat = 10;
    strobe(3'b001, 16'h7777, 16'h0000, 16'h0000);
    wait_out(1, 100);
    repeat (5) tick;
    clear_logs;
    strobe(3'b100, 16'h0000, 16'h0000, 16'h8888);
    wait_hs(10);
    tick;
    tick;
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk_all_zero("rstwait");
    repeat (20) tick;
    chk("rstwait_no_pulse", 64'(out_log.size()), 64'd0);
    chk("rstwait_ch_data", 64'(ch_data_out), 64'd0);
    clear_logs;
    strobe(3'b011, 16'h9999, 16'hAAAA, 16'h0000);
    wait_out(2, 100);
    if (out_log.size() > 1) begin
      chk("rstwait_first_ch",  64'(out_log[0].ch), 64'd0);
      chk("rstwait_second_ch", 64'(out_log[1].ch), 64'd1);
    end

    // Randomized traffic with short bounded backpressure.
    repeat (5) tick;
    do_reset;
    clear_logs;
    in_log.delete();
    fir_rand = 1'b1;
    lowrun   = 0;
    for (int c = 0; c < NCH; c++) last_t[c] = -1000;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      vmask = '0;
      vdata = {$urandom(), $urandom()};
      for (int c = 0; c < NCH; c++) begin
        if ((cyc - last_t[c]) >= 40 && $urandom_range(0, 3) == 0) begin
          rd = 16'($urandom());
          vmask[c] = 1'b1;
          vdata[c*W +: W] = rd;
          e.ch = 2'(c);
          e.d  = rd;
          in_log.push_back(e);
          last_t[c] = cyc;
        end
      end
      if (lowrun >= 2) fir_tready_in = 1'b1;
      else             fir_tready_in = ($urandom_range(0, 2) != 0);
      lowrun = fir_tready_in ? 0 : lowrun + 1;
      ch_valid_in = vmask;
      ch_data_in  = vdata;
      tick;
    end
    ch_valid_in   = '0;
    fir_tready_in = 1'b1;
    repeat (100) tick;
    fir_rand = 1'b0;

    for (int c = 0; c < NCH; c++) begin
      qi.delete();
      qo.delete();
      foreach (in_log[k])  if (in_log[k].ch == 2'(c))  qi.push_back(in_log[k].d);
      foreach (out_log[k]) if (out_log[k].ch == 2'(c)) qo.push_back(out_log[k].d);
      chk($sformatf("rnd_ch%0d_count", c), 64'(qo.size()), 64'(qi.size()));
      nmin = (qo.size() < qi.size()) ? qo.size() : qi.size();
      for (int k = 0; k < nmin; k++)
        chk($sformatf("rnd_ch%0d_s%0d", c, k), 64'(qo[k]), 64'(qi[k]));
      if (qi.size() > 0) begin
        hold_d = qi[qi.size()-1];
        chk($sformatf("rnd_ch%0d_hold", c), 64'(ch_data_out[c*W +: W]), 64'(hold_d));
      end
    end
    chk("rnd_overrun", 64'(overrun_out), 64'd0);
    chk("rnd_timeout", 64'(timeout_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
